uart_frame_parser: RTL and testbench

//  Consumes the byte stream from the UART receiver (rx_data plus one-cycle ready pulse) and assembles framed commands.

---
 rtl/uart_frame_parser.sv | 183 ++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_parser
// Description : Assembles framed commands (HDR0 HDR1 CMD LEN PAYLOAD CHK)
//               from a UART receiver byte stream. It checks the length and the
//               mod-256 checksum, buffers the payload, and emits one-cycle
//               valid/error pulses.
//               Optional inter-byte timeout: define UART_FRAME_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_parser #(
  parameter logic [7:0] HDR0        = 8'hAA,
  parameter logic [7:0] HDR1        = 8'h55,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 500000,
  localparam int        AW          = $clog2(MAX_LEN),
  localparam int        LW          = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          frm_valid,
  output logic [7:0]    frm_cmd,
  output logic [LW-1:0] frm_len,
  output logic          frm_err,
  output logic [1:0]    err_code
);

  localparam logic [7:0]    c_MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [LW-1:0] c_ONE_LW   = LW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_CMD  = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_CHK  = 3'd5
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_sum, w_sum_nxt;
  logic [LW-1:0] r_idx, w_idx_nxt;
  logic [7:0]    r_cmd, w_cmd_nxt;
  logic [LW-1:0] r_len, w_len_nxt;
  logic          w_valid_nxt;
  logic          w_err_nxt;
  logic [1:0]    w_code_nxt;
  logic          w_buf_we;
  logic [LW-1:0] w_len_m1;
  logic [7:0]    r_mem [2**AW];

  assign w_len_m1 = r_len - c_ONE_LW;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int          CW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] c_TMO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_tmo_cnt;
  logic          w_tmo_hit;

  // Timeout only fires on a byte-free cycle; a strobe always wins.
  assign w_tmo_hit = (r_state != S_IDLE) && !rx_ready && (r_tmo_cnt == c_TMO_LAST);

  // Inter-byte counter: cleared by every strobe and whenever idle.
  always_ff @(posedge clk) begin
    if (!rst_n || rx_ready || (r_state == S_IDLE) || w_tmo_hit) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + CW'(1);
    end
  end
`else
  logic w_timeout_unused;
  assign w_timeout_unused = (TIMEOUT_CYC == 0);
`endif

  // Next-state, datapath updates and pulse generation; advances only on strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_idx_nxt   = r_idx;
    w_cmd_nxt   = r_cmd;
    w_len_nxt   = r_len;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_code_nxt  = err_code;
    w_buf_we    = 1'b0;
    if (rx_ready) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == HDR0) w_state_nxt = S_HDR;
        end
        S_HDR: begin
          if (rx_data == HDR1)      w_state_nxt = S_CMD;
          else if (rx_data == HDR0) w_state_nxt = S_HDR;
          else                      w_state_nxt = S_IDLE;
        end
        S_CMD: begin
          w_cmd_nxt   = rx_data;
          w_sum_nxt   = rx_data;
          w_state_nxt = S_LEN;
        end
        S_LEN: begin
          w_sum_nxt = r_sum + rx_data;
          if (rx_data > c_MAX_LEN8) begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = 2'd1;
            w_state_nxt = S_IDLE;
          end else begin
            w_len_nxt   = rx_data[LW-1:0];
            w_idx_nxt   = '0;
            w_state_nxt = (rx_data == 8'd0) ? S_CHK : S_DATA;
          end
        end
        S_DATA: begin
          w_buf_we  = 1'b1;
          w_sum_nxt = r_sum + rx_data;
          w_idx_nxt = r_idx + c_ONE_LW;
          if (r_idx == w_len_m1) w_state_nxt = S_CHK;
        end
        S_CHK: begin
          if (rx_data == r_sum) begin
            w_valid_nxt = 1'b1;
          end else begin
            w_err_nxt  = 1'b1;
            w_code_nxt = 2'd2;
          end
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
`ifdef UART_FRAME_TIMEOUT_EN
    else if (w_tmo_hit) begin
      w_err_nxt   = 1'b1;
      w_code_nxt  = 2'd3;
      w_state_nxt = S_IDLE;
    end
`endif
  end

  // State, frame context, result outputs and registered buffer read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sum     <= '0;
      r_idx     <= '0;
      r_cmd     <= '0;
      r_len     <= '0;
      frm_valid <= 1'b0;
      frm_err   <= 1'b0;
      err_code  <= '0;
      frm_cmd   <= '0;
      frm_len   <= '0;
      rd_data   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sum     <= w_sum_nxt;
      r_idx     <= w_idx_nxt;
      r_cmd     <= w_cmd_nxt;
      r_len     <= w_len_nxt;
      frm_valid <= w_valid_nxt;
      frm_err   <= w_err_nxt;
      err_code  <= w_code_nxt;
      rd_data   <= r_mem[rd_addr];
      if (w_valid_nxt) begin
        frm_cmd <= r_cmd;
        frm_len <= r_len;
      end
    end
  end

  // Payload buffer: contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_buf_we) r_mem[r_idx[AW-1:0]] <= rx_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_parser
// Description : Directed table-driven bench for uart_frame_parser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_parser;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       frm_valid;
  logic [7:0] frm_cmd;
  logic [4:0] frm_len;
  logic       frm_err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_fail   = 0;

  uart_frame_parser #(
    .HDR0(8'hAA), .HDR1(8'h55), .MAX_LEN(16), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .frm_valid(frm_valid),
    .frm_cmd(frm_cmd), .frm_len(frm_len), .frm_err(frm_err),
    .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [191:0] b;
    int           n;
    logic         ev;
    logic         ee;
    logic [1:0]   code;
    logic [7:0]   cmd;
    logic [4:0]   len;
  } vec_t;

  function automatic vec_t mkv(input logic [191:0] raw, input int n,
                               input logic ev, input logic ee, input logic [1:0] code,
                               input logic [7:0] cmd, input logic [4:0] len);
    vec_t v;
    v.b    = raw << (8 * (24 - n));
    v.n    = n;
    v.ev   = ev;
    v.ee   = ee;
    v.code = code;
    v.cmd  = cmd;
    v.len  = len;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic read_chk(input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1;
    check($sformatf("rd_data[%0d]", a), {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic send_nopulse(input logic [7:0] b, input string nm);
    send(b);
    check(nm, {30'd0, frm_valid, frm_err}, 32'd0);
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = mkv(64'hAA55_1003_0102_0319, 8, 1'b1, 1'b0, 2'd0, 8'h10, 5'd3);
    vecs[1] = mkv(64'hAA55_1003_0102_031A, 8, 1'b0, 1'b1, 2'd2, 8'h10, 5'd3);
    vecs[2] = mkv(32'hAA55_2011,           4, 1'b0, 1'b1, 2'd1, 8'h10, 5'd3);
    vecs[3] = mkv(40'hAA_5521_0021,        5, 1'b1, 1'b0, 2'd1, 8'h21, 5'd0);
    vecs[4] = mkv(56'h00_AAAA_5505_0005,   7, 1'b1, 1'b0, 2'd1, 8'h05, 5'd0);
    vecs[5] = mkv({24'hAA5507, 8'h10, {16{8'hFF}}, 8'h07},
                                           21, 1'b1, 1'b0, 2'd1, 8'h07, 5'd16);
    vecs[6] = mkv(48'hAA55_AA01_AA55,      6, 1'b1, 1'b0, 2'd1, 8'hAA, 5'd1);
    vecs[7] = mkv(56'hAA_5533_0201_0137,   7, 1'b1, 1'b0, 2'd1, 8'h33, 5'd2);
    vecs[8] = mkv(32'hAA55_01FF,           4, 1'b0, 1'b1, 2'd1, 8'h33, 5'd2);
    vecs[9] = mkv(56'hAA_12AA_5502_0002,   7, 1'b1, 1'b0, 2'd1, 8'h02, 5'd0);

    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    rd_addr  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset frm_valid", {31'd0, frm_valid}, 32'd0);
    check("reset frm_err",   {31'd0, frm_err},   32'd0);
    check("reset err_code",  {30'd0, err_code},  32'd0);
    check("reset frm_cmd",   {24'd0, frm_cmd},   32'd0);
    check("reset frm_len",   {27'd0, frm_len},   32'd0);
    check("reset rd_data",   {24'd0, rd_data},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < vecs[k].n; i++) begin
        send(vecs[k].b[191 - 8*i -: 8]);
        if (i < vecs[k].n - 1)
          check($sformatf("v%0d b%0d no pulse", k, i), {30'd0, frm_valid, frm_err}, 32'd0);
      end
      check($sformatf("v%0d frm_valid", k), {31'd0, frm_valid}, {31'd0, vecs[k].ev});
      check($sformatf("v%0d frm_err", k),   {31'd0, frm_err},   {31'd0, vecs[k].ee});
      check($sformatf("v%0d err_code", k),  {30'd0, err_code},  {30'd0, vecs[k].code});
      check($sformatf("v%0d frm_cmd", k),   {24'd0, frm_cmd},   {24'd0, vecs[k].cmd});
      check($sformatf("v%0d frm_len", k),   {27'd0, frm_len},   {27'd0, vecs[k].len});
      if (k == 0) begin
        read_chk(4'd0, 8'h01);
        read_chk(4'd1, 8'h02);
        read_chk(4'd2, 8'h03);
      end else if (k == 5) begin
        read_chk(4'd0, 8'hFF);
        read_chk(4'd15, 8'hFF);
      end else if (k == 6) begin
        read_chk(4'd0, 8'hAA);
      end
    end

    @(posedge clk);
    #1;
    check("pulse width", {30'd0, frm_valid, frm_err}, 32'd0);

    // Reset in the middle of a frame: no pulse, outputs cleared, tail bytes ignored.
    send_nopulse(8'hAA, "mid rst b0");
    send_nopulse(8'h55, "mid rst b1");
    send_nopulse(8'h30, "mid rst b2");
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid rst frm_cmd",  {24'd0, frm_cmd},  32'd0);
    check("mid rst frm_len",  {27'd0, frm_len},  32'd0);
    check("mid rst err_code", {30'd0, err_code}, 32'd0);
    check("mid rst pulses",   {30'd0, frm_valid, frm_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_nopulse(8'h30, "post rst t0");
    send_nopulse(8'h00, "post rst t1");
    send_nopulse(8'h30, "post rst t2");
    @(posedge clk);
    #1;
    check("post rst idle", {30'd0, frm_valid, frm_err}, 32'd0);
    send(8'hAA); send(8'h55); send(8'h30); send(8'h00); send(8'h30);
    check("post rst frm_valid", {31'd0, frm_valid}, 32'd1);
    check("post rst frm_cmd",   {24'd0, frm_cmd},   32'h30);

`ifdef UART_FRAME_TIMEOUT_EN
    send(8'hAA);
    send(8'h55);
    repeat (99) @(posedge clk);
    #1;
    check("tmo early", {31'd0, frm_err}, 32'd0);
    @(posedge clk);
    #1;
    check("tmo frm_err",  {31'd0, frm_err},  32'd1);
    check("tmo err_code", {30'd0, err_code}, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
